vga_sync_controller: RTL and testbench

- Sequences the text/pixel generator datapath. Produces the pixel_x/pixel_y scan coordinates, video_on, hsync and vsync that drive GeneradosDatos-style generators.
- Divides the system clock down to the pixel rate and emits a single-cycle p_tick enable. It also emits a per-frame strobe so downstream logic can latch configuration (e.g. switch values) at frame boundaries only.

---
 rtl/vga_sync_controller.sv | 104 ++++++++++
 tb/tb_vga_sync_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_controller.sv
// VGA scan timing: pixel-rate divider, pixel/line counters and registered
// sync/blanking qualifiers that are aligned with the coordinates they describe.
module vga_sync_controller #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             div_wrap;
    logic             line_wrap;
    logic             frame_wrap;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             p_tick_q;
    logic             frame_q;

    // Next-state counters; the qualifiers below are derived from these so
    // that they land in the same cycle as the coordinates they describe.
    always_comb begin
        div_wrap   = enable && (div_cnt == DIV_MAX);
        line_wrap  = div_wrap && (pixel_x == H_MAX);
        frame_wrap = line_wrap && (pixel_y == V_MAX);

        div_next = div_cnt;
        if (enable) begin
            div_next = div_wrap ? '0 : div_cnt + DIV_W'(1);
        end

        x_next = pixel_x;
        if (div_wrap) begin
            x_next = line_wrap ? 10'd0 : pixel_x + 10'd1;
        end

        y_next = pixel_y;
        if (line_wrap) begin
            y_next = frame_wrap ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Everything freezes while enable is low, so resuming continues the scan
    // from exactly the pixel it stopped on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            pixel_x  <= 10'd0;
            pixel_y  <= 10'd0;
            p_tick_q <= 1'b0;
            video_on <= 1'b0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            frame_q  <= 1'b0;
        end else if (enable) begin
            div_cnt  <= div_next;
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            p_tick_q <= div_wrap;
            video_on <= (x_next < H_VIS) && (y_next < V_VIS);
            hsync    <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync    <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            frame_q  <= frame_wrap;
        end else begin
            p_tick_q <= 1'b0;
            frame_q  <= 1'b0;
        end
    end

    // Strobes are gated so they drop in the very cycle enable goes low.
    assign p_tick      = p_tick_q & enable;
    assign frame_start = frame_q & enable;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Scoreboard bench: a default-timing instance (CLK_DIV=4) and a tiny-geometry
// instance (CLK_DIV=1) so that whole frames fit in a short run.
module tb_vga_sync_controller;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       rst0, en0, rst1, en1;
    logic       p_tick0, video_on0, hsync0, vsync0, frame_start0;
    logic       p_tick1, video_on1, hsync1, vsync1, frame_start1;
    logic [9:0] pixel_x0, pixel_y0, pixel_x1, pixel_y1;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   en_edges0    = 0;
    int   last_edge0   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    vga_sync_controller dut0 (
        .clk(clk), .reset(rst0), .enable(en0), .p_tick(p_tick0),
        .pixel_x(pixel_x0), .pixel_y(pixel_y0), .video_on(video_on0),
        .hsync(hsync0), .vsync(vsync0), .frame_start(frame_start0)
    );

    vga_sync_controller #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .p_tick(p_tick1),
        .pixel_x(pixel_x1), .pixel_y(pixel_y1), .video_on(video_on1),
        .hsync(hsync1), .vsync(vsync1), .frame_start(frame_start1)
    );

    always #5 clk = ~clk;

    // Reference pixel k after reset release, 800x525 default timing.
    function automatic exp_t model0(input int k);
        exp_t e;
        int x, y;
        x = k % 800;
        y = (k / 800) % 525;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.vid = (x < 640) && (y < 480);
        e.hs  = !((x >= 656) && (x <= 751));
        e.vs  = !((y >= 490) && (y <= 491));
        e.fs  = (x == 0) && (y == 0);
        return e;
    endfunction

    // Reference for the 15x10 geometry: hsync low 10..12, vsync low 7..8.
    function automatic exp_t model1(input int k);
        exp_t e;
        int x, y;
        x = k % 15;
        y = (k / 15) % 10;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.vid = (x < 8) && (y < 6);
        e.hs  = !((x >= 10) && (x <= 12));
        e.vs  = !((y >= 7) && (y <= 8));
        e.fs  = (x == 0) && (y == 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkPixel(input string name, input exp_t act, input exp_t exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got x=%0d y=%0d vid=%b hs=%b vs=%b fs=%b, expected x=%0d y=%0d vid=%b hs=%b vs=%b fs=%b",
                     name, act.x, act.y, act.vid, act.hs, act.vs, act.fs,
                     exp.x, exp.y, exp.vid, exp.hs, exp.vs, exp.fs);
        end
    endtask

    // Queue the expected pixels, then release the chosen instance.
    task automatic applyStimulus(input int dut, input int n_pixels);
        for (int k = 1; k <= n_pixels; k++) begin
            if (dut == 0) q0.push_back(model0(k));
            else          q1.push_back(model1(k));
        end
        if (dut == 0) begin
            rst0 = 1'b0;
            en0  = 1'b1;
        end else begin
            rst1 = 1'b0;
            en1  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (!rst0 && en0) en_edges0++;
    end

    // Monitor: every p_tick presents a pixel that must match the queue head.
    always @(negedge clk) begin
        if (p_tick0) begin
            if (q0.size() == 0) begin
                checkOutput("dut0_unexpected_tick", 1, 0);
            end else begin
                mon_e = q0.pop_front();
                checkPixel("dut0_pixel", {pixel_x0, pixel_y0, video_on0, hsync0, vsync0, frame_start0}, mon_e);
                checkOutput("dut0_tick_gap", en_edges0 - last_edge0, 4);
            end
            last_edge0 = en_edges0;
        end
        if (p_tick1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1_unexpected_tick", 1, 0);
            end else begin
                mon_e = q1.pop_front();
                checkPixel("dut1_pixel", {pixel_x1, pixel_y1, video_on1, hsync1, vsync1, frame_start1}, mon_e);
            end
        end
    end

    initial begin
        logic found;
        clk  = 1'b0;
        rst0 = 1'b0;
        rst1 = 1'b0;
        en0  = 1'b0;
        en1  = 1'b0;
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("dut0_reset", int'({pixel_x0, pixel_y0, video_on0, hsync0, vsync0, p_tick0, frame_start0}),
                    int'({10'd0, 10'd0, 5'b01100}));
        checkOutput("dut1_reset", int'({pixel_x1, pixel_y1, video_on1, hsync1, vsync1, p_tick1, frame_start1}),
                    int'({10'd0, 10'd0, 5'b01100}));

        // Default timing: one full line plus half of the next.
        applyStimulus(0, 1200);
        @(posedge clk);
        #2;
        checkOutput("dut0_first_edge", int'({pixel_x0, pixel_y0, video_on0, hsync0, vsync0, p_tick0, frame_start0}),
                    int'({10'd0, 10'd0, 5'b11100}));

        found = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #2;
            if (pixel_x0 == 10'd300 && pixel_y0 == 10'd1 && !p_tick0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("dut0_reach_300", int'(found), 1);
        en0 = 1'b0;
        repeat (100) begin
            @(negedge clk);
            checkOutput("dut0_hold", int'({pixel_x0, pixel_y0, video_on0, hsync0, vsync0, p_tick0, frame_start0}),
                        int'({10'd300, 10'd1, 5'b11100}));
        end
        @(posedge clk);
        #2;
        en0 = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0) break;
        end
        en0 = 1'b0;
        checkOutput("dut0_drained", q0.size(), 0);

        // CLK_DIV=1 small geometry: two frames, stopping at (12,4).
        @(posedge clk);
        #2;
        applyStimulus(1, 372);
        repeat (372) @(posedge clk);
        #7;
        en1 = 1'b0;
        #1;
        checkOutput("dut1_drained", q1.size(), 0);
        checkOutput("dut1_stop_state", int'({pixel_x1, pixel_y1, video_on1, hsync1, vsync1, p_tick1, frame_start1}),
                    int'({10'd12, 10'd4, 5'b00100}));

        // Asynchronous reset mid-cycle, then restart with no frame strobe.
        @(posedge clk);
        #3;
        rst1 = 1'b1;
        #1;
        checkOutput("dut1_async_reset", int'({pixel_x1, pixel_y1, video_on1, hsync1, vsync1, p_tick1, frame_start1}),
                    int'({10'd0, 10'd0, 5'b01100}));
        repeat (2) @(posedge clk);
        #2;
        applyStimulus(1, 20);
        repeat (20) @(posedge clk);
        #7;
        en1 = 1'b0;
        #1;
        checkOutput("dut1_restart_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
